// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns a pipelined LW/SW into a held request to a
// multi-cycle data memory and freezes the pipeline until the memory acks or times out.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [5:0]  OP_LW   = 6'b100011,
  parameter logic [5:0]  OP_SW   = 6'b101011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M_valid,
  input  logic [5:0]  M_op,
  input  logic [31:0] M_valE,
  input  logic [31:0] M_valA,
  output logic [31:0] m_valM,
  output logic        m_stall,
  output logic        m_done,
  output logic        m_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_memReq;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_valM;
  logic              r_err;

  logic              w_memop;
  logic              w_start;
  logic              w_ackHit;
  logic              w_timeout;

  assign w_memop   = M_valid && ((M_op == OP_LW) || (M_op == OP_SW));
  assign w_start   = (r_state == S_IDLE) && w_memop;
  assign w_ackHit  = (r_state == S_REQ) && mem_ack;
  // Ack has priority over an expiring counter on the same edge.
  assign w_timeout = (r_state == S_REQ) && !mem_ack && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_memop) begin
          w_nextState = S_REQ;
        end
      end
      S_REQ: begin
        if (w_ackHit || w_timeout) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_comb begin
    m_stall = 1'b0;
    m_done  = 1'b0;
    unique case (r_state)
      S_IDLE:  m_stall = w_memop;
      S_REQ:   m_stall = 1'b1;
      S_DONE:  m_done  = 1'b1;
      default: begin
        m_stall = 1'b0;
        m_done  = 1'b0;
      end
    endcase
  end

  // Request fields are loaded only when an access is accepted, so they stay put while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memReq <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_cnt    <= '0;
    end else if (w_start) begin
      r_memReq <= 1'b1;
      r_we     <= (M_op == OP_SW);
      r_addr   <= M_valE;
      r_wdata  <= M_valA;
      r_cnt    <= '0;
    end else if (w_ackHit || w_timeout) begin
      r_memReq <= 1'b0;
    end else if ((r_state == S_REQ) && (r_cnt != CNT_LAST)) begin
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valM <= 32'h0;
      r_err  <= 1'b0;
    end else begin
      if (w_ackHit && !r_we) begin
        r_valM <= mem_rdata;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign m_valM    = r_valM;
  assign m_err     = r_err;
  assign mem_req   = r_memReq;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  aWaitHolds: assert property (@(posedge clk) disable iff (!rst_n)
    ((r_state == S_REQ) && !mem_ack && (r_cnt != CNT_LAST)) |=>
      ((r_state == S_REQ) && r_memReq && $stable(r_addr) && $stable(r_wdata) && $stable(r_we)));

  aDoneToIdle: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_DONE) |=> (r_state == S_IDLE));

  aErrSticky: assert property (@(posedge clk) disable iff (!rst_n)
    r_err |=> r_err);

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum cycles spent in REQ waiting for mem_ack.
REQ-002 Parameter OP_LW, default 6'b100011, SHALL be the load opcode (ILW).
REQ-003 Parameter OP_SW, default 6'b101011, SHALL be the store opcode (ISW).
REQ-004 clk  input  1  sole clock; all state SHALL change on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 M_valid  input  1  memory-stage register holds a valid instruction.
REQ-007 M_op  input  6  memory-stage opcode.
REQ-008 M_valE  input  32  word address from execute.
REQ-009 M_valA  input  32  store data.
REQ-010 m_valM  output  32  load result to writeback.
REQ-011 m_stall  output  1  freeze the pipeline upstream of and including the memory stage.
REQ-012 m_done  output  1  one-cycle pulse: access complete.
REQ-013 m_err  output  1  sticky timeout flag.
REQ-014 mem_req  output  1  request to the multi-cycle data memory.
REQ-015 mem_we  output  1  1 = store, 0 = load.
REQ-016 mem_addr  output  32  request address.
REQ-017 mem_wdata  output  32  store data.
REQ-018 mem_ack  input  1  memory responder completion; valid only while mem_req = 1.
REQ-019 mem_rdata  input  32  load data; valid in the cycle mem_ack = 1 and mem_we = 0.

Function
REQ-020 The block SHALL implement FSM states IDLE, REQ and DONE.
REQ-021 memop SHALL be defined as M_valid && (M_op == OP_LW || M_op == OP_SW).
REQ-022 IDLE with memop at the edge: go to REQ; register mem_req = 1, mem_we = (M_op == OP_SW), mem_addr = M_valE, mem_wdata = M_valA; clear the timeout counter.
REQ-023 IDLE without memop: stay in IDLE; mem_req = 0; m_valM unchanged; no request for any other opcode (e.g. IROP, IJ).
REQ-024 m_stall SHALL be combinational: 1 when (IDLE && memop) or in REQ; 0 in DONE and otherwise.
REQ-025 In REQ, mem_req, mem_we, mem_addr and mem_wdata SHALL hold stable until mem_ack is sampled high.
REQ-026 REQ with mem_ack = 1 at the edge: go to DONE; mem_req = 0; on a load, m_valM <= mem_rdata; on a store, m_valM is unchanged.
REQ-027 REQ without mem_ack: increment the counter; when the count reaches TIMEOUT-1 with no ack, go to DONE, set mem_req = 0, set m_err = 1, and leave m_valM unchanged.
REQ-028 mem_ack and the timeout on the same edge: the ack SHALL win; m_err is not set.
REQ-029 m_done SHALL be 1 exactly during the DONE cycle.
REQ-030 DONE SHALL always go to IDLE on the next edge, even if memop = 1; the pipeline advances during DONE, so the old instruction is not reissued.
REQ-031 Minimum access latency: memop seen at edge N, mem_req high after N, ack at edge N+1, m_done during cycle N+1..N+2, 3 cycles total; stall held for 2 cycles.
REQ-032 mem_ack while mem_req = 0 SHALL be ignored.
REQ-033 m_err SHALL remain 1 until reset.
REQ-034 The timeout counter SHALL be wide enough for TIMEOUT and SHALL NOT wrap.

Reset
REQ-035 While rst_n = 0, the block SHALL be in IDLE with mem_req, mem_we, m_done and m_err = 0; m_valM, mem_addr and mem_wdata = 32'h0; the counter = 0.
REQ-036 Reset asserted in REQ or DONE SHALL abort the access immediately with no m_done pulse; the first access after release starts from IDLE.

Verification
REQ-037 Store: OP_SW, M_valE = 1, M_valA = 1, ack 2 cycles later -> mem_we = 1, mem_addr = 1, mem_wdata = 1 held stable; m_stall high for 3 cycles; single m_done pulse; m_valM unchanged.
REQ-038 Load: OP_LW, M_valE = 2, ack with mem_rdata = 32'h2 -> m_valM = 32'h2 in DONE; m_done pulses once.
REQ-039 Non-memory opcode (IROP/IJ), M_valE = 3 -> mem_req never asserts; m_stall = 0; m_valM unchanged.
REQ-040 Timeout: OP_LW with mem_ack tied low, TIMEOUT = 16 -> mem_req drops after 16 REQ cycles; m_err = 1 and sticky; m_done pulses; m_valM unchanged.
REQ-041 Ack on the timeout edge -> load data captured and m_err = 0; stray mem_ack pulses in IDLE -> no state change.
REQ-042 Back-to-back: OP_SW then OP_LW at the same address -> DONE passes through IDLE before the second mem_req; no reissue of the first op; then rst_n low mid-REQ -> all outputs return to reset values asynchronously.
